sigmoid_pwl_offset_gen: RTL and testbench

//  - 2-stage pipelined PLAN piecewise-linear sigmoid front end for the VAE sigmoid path.
//  - Evaluates y = f(|x|) on the magnitude of a signed fixed-point input.
//  - Produces plus_offset = y and minus_offset = ONE - y, plus the delayed input as sign_bit.
//  - Feeds sign_based_mux directly: sign_bit -> its sign_bit, plus/minus_offset -> same-named ports.

---
 rtl/sigmoid_pwl_pkg.sv | 25 ++
 rtl/sigmoid_pwl_segment.sv | 45 ++++
 rtl/sigmoid_pwl_offset_gen.sv | 94 +++++++++
 tb/tb_sigmoid_pwl_offset_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pwl_pkg.sv
// Shared constants for the PLAN piecewise-linear sigmoid front end.
// Q-format constants are derived from the fractional bit count through q_scale().
package sigmoid_pwl_pkg;

    localparam int Q_FRAC = 8;

    localparam logic [1:0] SEG0 = 2'd0;
    localparam logic [1:0] SEG1 = 2'd1;
    localparam logic [1:0] SEG2 = 2'd2;
    localparam logic [1:0] SEG3 = 2'd3;

    // mant / 2^exp2 expressed with 'frac' fractional bits (requires frac >= exp2)
    function automatic int q_scale(input int mant, input int exp2, input int frac);
        return mant << (frac - exp2);
    endfunction

    localparam int ONE       = q_scale(1, 0, Q_FRAC);
    localparam int HALF      = q_scale(1, 1, Q_FRAC);
    localparam int C_0P625   = q_scale(5, 3, Q_FRAC);
    localparam int C_0P84375 = q_scale(27, 5, Q_FRAC);
    localparam int BRK_1P0   = q_scale(1, 0, Q_FRAC);
    localparam int BRK_2P375 = q_scale(19, 3, Q_FRAC);
    localparam int BRK_5P0   = q_scale(5, 0, Q_FRAC);

endpackage

// File: rtl/sigmoid_pwl_segment.sv
// Combinational PLAN segment logic: segment select from |x|, and segment evaluation y = f(|x|).
// Selection and evaluation are separate paths so they can sit in different pipeline stages.
module sigmoid_pwl_segment
    import sigmoid_pwl_pkg::*;
#(
    parameter int BITS = 16,
    parameter int FRAC = 8
) (
    input  logic [BITS-1:0] sel_ax_i,
    output logic [1:0]      seg_o,
    input  logic [BITS-1:0] ax_i,
    input  logic [1:0]      seg_i,
    output logic [BITS-1:0] y_o
);

    localparam logic [BITS-1:0] K_ONE   = BITS'(q_scale(1, 0, FRAC));
    localparam logic [BITS-1:0] K_HALF  = BITS'(q_scale(1, 1, FRAC));
    localparam logic [BITS-1:0] K_C1    = BITS'(q_scale(5, 3, FRAC));
    localparam logic [BITS-1:0] K_C2    = BITS'(q_scale(27, 5, FRAC));
    localparam logic [BITS-1:0] K_BRK1  = BITS'(q_scale(1, 0, FRAC));
    localparam logic [BITS-1:0] K_BRK2  = BITS'(q_scale(19, 3, FRAC));
    localparam logic [BITS-1:0] K_BRK5  = BITS'(q_scale(5, 0, FRAC));

    // Breakpoint values fall into the upper segment
    always_comb begin
        seg_o = SEG3;
        if (sel_ax_i < K_BRK1)
            seg_o = SEG0;
        else if (sel_ax_i < K_BRK2)
            seg_o = SEG1;
        else if (sel_ax_i < K_BRK5)
            seg_o = SEG2;
    end

    always_comb begin
        y_o = K_ONE;
        case (seg_i)
            SEG0:    y_o = (ax_i >> 2) + K_HALF;
            SEG1:    y_o = (ax_i >> 3) + K_C1;
            SEG2:    y_o = (ax_i >> 5) + K_C2;
            default: y_o = K_ONE;
        endcase
    end

endmodule

// File: rtl/sigmoid_pwl_offset_gen.sv
// Two-stage PLAN sigmoid front end: stage 1 takes |x| and picks a segment,
// stage 2 evaluates y and registers y / ONE-y / delayed x for sign_based_mux.
module sigmoid_pwl_offset_gen
    import sigmoid_pwl_pkg::*;
#(
    parameter int BITS = 16,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] x_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] sign_bit,
    output logic [BITS-1:0] plus_offset,
    output logic [BITS-1:0] minus_offset
);

    localparam logic [BITS-1:0] K_ONE   = BITS'(q_scale(1, 0, FRAC));
    localparam logic [BITS-1:0] K_MIN   = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] K_MAX   = {1'b0, {(BITS-1){1'b1}}};

    // The most negative input has no positive twin, so it saturates
    function automatic logic [BITS-1:0] abs_sat(input logic [BITS-1:0] v);
        if (v == K_MIN)
            return K_MAX;
        else if (v[BITS-1])
            return (~v) + 1'b1;
        else
            return v;
    endfunction

    logic            en;
    logic [BITS-1:0] ax_d;
    logic [1:0]      seg_d;
    logic [BITS-1:0] y_d;

    logic            vld_p1_q;
    logic [BITS-1:0] ax_p1_q;
    logic [1:0]      seg_p1_q;
    logic [BITS-1:0] x_p1_q;

    logic            vld_p2_q;
    logic [BITS-1:0] sign_p2_q;
    logic [BITS-1:0] plus_p2_q;
    logic [BITS-1:0] minus_p2_q;

    assign en       = !vld_p2_q || out_ready;
    assign in_ready = en;
    assign ax_d     = abs_sat(x_in);

    sigmoid_pwl_segment #(
        .BITS (BITS),
        .FRAC (FRAC)
    ) u_segment (
        .sel_ax_i (ax_d),
        .seg_o    (seg_d),
        .ax_i     (ax_p1_q),
        .seg_i    (seg_p1_q),
        .y_o      (y_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            ax_p1_q    <= '0;
            seg_p1_q   <= SEG0;
            x_p1_q     <= '0;
            vld_p2_q   <= 1'b0;
            sign_p2_q  <= '0;
            plus_p2_q  <= '0;
            minus_p2_q <= '0;
        end else if (en) begin
            // stage 1: magnitude and segment select
            vld_p1_q   <= in_valid;
            ax_p1_q    <= ax_d;
            seg_p1_q   <= seg_d;
            x_p1_q     <= x_in;
            // stage 2: evaluate and form both offsets
            vld_p2_q   <= vld_p1_q;
            sign_p2_q  <= x_p1_q;
            plus_p2_q  <= y_d;
            minus_p2_q <= K_ONE - y_d;
        end
    end

    assign out_valid    = vld_p2_q;
    assign sign_bit     = sign_p2_q;
    assign plus_offset  = plus_p2_q;
    assign minus_offset = minus_p2_q;

endmodule

// File: tb/tb_sigmoid_pwl_offset_gen.sv
// Directed-vector bench for sigmoid_pwl_offset_gen: table of hand-computed points,
// stream/stall/reset sequences, and a scoreboarded sweep against a reference model.
module tb_sigmoid_pwl_offset_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sign_bit;
    logic [15:0] plus_offset;
    logic [15:0] minus_offset;

    int nvec = 0;
    int nmiss = 0;

    sigmoid_pwl_offset_gen #(.BITS(16), .FRAC(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_in         (x_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sign_bit     (sign_bit),
        .plus_offset  (plus_offset),
        .minus_offset (minus_offset)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference f(|x|) written with integer floor division
    function automatic logic [15:0] ref_plus(input logic [15:0] x);
        int v;
        int ax;
        int y;
        v  = int'($signed(x));
        ax = (v < 0) ? -v : v;
        if (ax > 32767) ax = 32767;
        if (ax < 256)       y = ax / 4 + 128;
        else if (ax < 608)  y = ax / 8 + 160;
        else if (ax < 1280) y = ax / 32 + 216;
        else                y = 256;
        return 16'(y);
    endfunction

    typedef struct {
        logic [15:0] x;
        logic [15:0] p;
        logic [15:0] m;
    } vec_t;

    vec_t        tbl[13];
    logic [15:0] strm[8];
    logic [15:0] xs[$];
    logic [15:0] sbq[$];

    initial begin
        tbl[0]  = '{16'h0000, 16'h0080, 16'h0080};
        tbl[1]  = '{16'h0080, 16'h00A0, 16'h0060};
        tbl[2]  = '{16'h0100, 16'h00C0, 16'h0040};
        tbl[3]  = '{16'hFF00, 16'h00C0, 16'h0040};
        tbl[4]  = '{16'h0300, 16'h00F0, 16'h0010};
        tbl[5]  = '{16'h0500, 16'h0100, 16'h0000};
        tbl[6]  = '{16'h8000, 16'h0100, 16'h0000};
        tbl[7]  = '{16'h00FF, 16'h00BF, 16'h0041};
        tbl[8]  = '{16'h025F, 16'h00EB, 16'h0015};
        tbl[9]  = '{16'h0260, 16'h00EB, 16'h0015};
        tbl[10] = '{16'h04FF, 16'h00FF, 16'h0001};
        tbl[11] = '{16'h7FFF, 16'h0100, 16'h0000};
        tbl[12] = '{16'hFF01, 16'h00BF, 16'h0041};

        // reset state
        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst plus", 32'(plus_offset), 32'd0);
        chk("rst minus", 32'(minus_offset), 32'd0);
        chk("rst sign", 32'(sign_bit), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        step();

        // table: one sample at a time, output two cycles after accept
        for (int i = 0; i < 13; i++) begin
            x_in = tbl[i].x;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d lat1 valid", i), 32'(out_valid), 32'd0);
            step();
            chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d plus", i), 32'(plus_offset), 32'(tbl[i].p));
            chk($sformatf("tbl%0d minus", i), 32'(minus_offset), 32'(tbl[i].m));
            chk($sformatf("tbl%0d sign", i), 32'(sign_bit), 32'(tbl[i].x));
        end
        step();

        // back-to-back stream of 8
        for (int i = 0; i < 8; i++) strm[i] = 16'(i * 160 - 400);
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            x_in = (k < 8) ? strm[k] : 16'h0;
            step();
            if (k >= 1 && k <= 8) begin
                chk($sformatf("strm%0d valid", k - 1), 32'(out_valid), 32'd1);
                chk($sformatf("strm%0d sign", k - 1), 32'(sign_bit), 32'(strm[k-1]));
                chk($sformatf("strm%0d plus", k - 1), 32'(plus_offset), 32'(ref_plus(strm[k-1])));
            end else begin
                chk($sformatf("strm bubble k%0d", k), 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;

        // stall with two samples in flight
        x_in = 16'h0080; in_valid = 1'b1;
        step();
        x_in = 16'hFF00;
        step();
        chk("stall A valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        x_in = 16'h0500;
        #1;
        chk("stall in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall c%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall c%0d sign", c), 32'(sign_bit), 32'h0080);
            chk($sformatf("stall c%0d plus", c), 32'(plus_offset), 32'h00A0);
            chk($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        step();
        chk("stall B valid", 32'(out_valid), 32'd1);
        chk("stall B sign", 32'(sign_bit), 32'hFF00);
        chk("stall B plus", 32'(plus_offset), 32'h00C0);
        step();
        chk("stall drained", 32'(out_valid), 32'd0);

        // reset mid-stream
        x_in = 16'h0300; in_valid = 1'b1;
        step();
        x_in = 16'h0100;
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst valid", 32'(out_valid), 32'd0);
        chk("midrst plus", 32'(plus_offset), 32'd0);
        chk("midrst minus", 32'(minus_offset), 32'd0);
        chk("midrst sign", 32'(sign_bit), 32'd0);
        #1;
        rst = 1'b0;
        x_in = 16'h8000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("postrst lat1 valid", 32'(out_valid), 32'd0);
        step();
        chk("postrst valid", 32'(out_valid), 32'd1);
        chk("postrst sign", 32'(sign_bit), 32'h8000);
        chk("postrst plus", 32'(plus_offset), 32'h0100);
        chk("postrst minus", 32'(minus_offset), 32'h0000);
        step();

        // sweep 0x8000..0x7FFF with random back-pressure
        for (int v = -32768; v <= 32767; v += 37) xs.push_back(16'(v));
        xs.push_back(16'h7FFF);
        begin
            int idx = 0;
            int cyc = 0;
            logic acc, drn;
            logic [15:0] op, om, os, e;
            while ((idx < xs.size() || sbq.size() > 0) && cyc < 20000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = (idx < xs.size());
                x_in      = (idx < xs.size()) ? xs[idx] : 16'h0;
                #1;
                acc = in_valid && in_ready;
                drn = out_valid && out_ready;
                op = plus_offset; om = minus_offset; os = sign_bit;
                @(posedge clk);
                #1;
                if (drn) begin
                    if (sbq.size() == 0) begin
                        chk("sweep spurious output", 32'(os), 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("sweep x=%h sign", e), 32'(os), 32'(e));
                        chk($sformatf("sweep x=%h plus", e), 32'(op), 32'(ref_plus(e)));
                        chk($sformatf("sweep x=%h minus", e), 32'(om), 32'(16'h0100 - ref_plus(e)));
                    end
                end
                if (acc) begin
                    sbq.push_back(xs[idx]);
                    idx++;
                end
                cyc++;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            chk("sweep outstanding", 32'(sbq.size() + (xs.size() - idx)), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
